parity_word_receiver: RTL and testbench

Serial-side receiver for the 9-bit parity word (8 data bits plus 1 parity bit) produced by the parity generator. It deserializes a framed word from a single-bit line and recovers the 8 data bits. It checks parity against the selected even/odd mode and flags errors. It sits at the consuming end of the link and hands a validated byte plus status to downstream logic.

---
 rtl/parity_rx_pkg.sv | 15 +
 rtl/parity_rx_bit_timer.sv | 35 +++
 rtl/parity_word_receiver.sv | 132 +++++++++++++
 tb/tb_parity_word_receiver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_rx_pkg.sv
// Shared constants for the parity word link: receiver state encodings and parity modes.
package parity_rx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_rx_bit_timer.sv
// Per-bit cycle counter for the parity word receiver; strobes once per bit at mid-bit.
module parity_rx_bit_timer #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic realign,
  output logic strobe
);

  localparam int unsigned CntW = $clog2(BIT_CYCLES);
  localparam logic [CntW-1:0] Mid  = CntW'(BIT_CYCLES / 2 - 1);
  localparam logic [CntW-1:0] Last = CntW'(BIT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  // The detection cycle counts as cycle 0, so a clear loads 1 for the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= CntW'(1);
    end else if (realign) begin
      cnt_q <= Mid + CntW'(1);
    end else if (cnt_q == Last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign strobe = (cnt_q == Mid);

endmodule

// File: rtl/parity_word_receiver.sv
// Serial receiver for 8-data + parity words with even/odd check.
// Define FRAMING_CHECK_EN to add the frame_error output (stop-bit check).
module parity_word_receiver
  import parity_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              parity_control,
  output logic [DATA_W-1:0] data_out,
  output logic              word_valid,
  output logic              parity_error,
`ifdef FRAMING_CHECK_EN
  output logic              frame_error,
`endif
  output logic              busy
);

  localparam int unsigned BitCntW = $clog2(DATA_W);

  logic [1:0]         sync_q;
  logic               rx_s;
  rx_state_e          state_q;
  logic               mode_q;
  logic [DATA_W-1:0]  shift_q;
  logic [BitCntW-1:0] bit_cnt_q;
  logic               p_q;
  logic               stop_q;
  logic               done_q;
  logic               armed_q;
  logic               strobe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], serial_in};
    end
  end

  assign rx_s = sync_q[1];

  parity_rx_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == StIdle),
    .realign(state_q == StStart && strobe && !rx_s),
    .strobe (strobe)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      mode_q       <= PARITY_EVEN;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      p_q          <= 1'b0;
      stop_q       <= 1'b1;
      done_q       <= 1'b0;
      armed_q      <= 1'b1;
      data_out     <= '0;
      word_valid   <= 1'b0;
      parity_error <= 1'b0;
`ifdef FRAMING_CHECK_EN
      frame_error  <= 1'b0;
`endif
    end else begin
      word_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= StStart;
            mode_q  <= parity_control;
          end
        end
        StStart: begin
          if (strobe) begin
            if (rx_s) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
        end
        StData: begin
          if (strobe) begin
            shift_q   <= {rx_s, shift_q[DATA_W-1:1]};
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            if (bit_cnt_q == BitCntW'(DATA_W - 1)) begin
              state_q <= StParity;
            end
          end
        end
        StParity: begin
          if (strobe) begin
            p_q     <= rx_s;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (done_q) begin
            done_q       <= 1'b0;
            data_out     <= shift_q;
            parity_error <= ((^shift_q) ^ p_q) != mode_q;
            word_valid   <= 1'b1;
`ifdef FRAMING_CHECK_EN
            frame_error  <= !stop_q;
`endif
            // An all-zero frame is a held-low line; wait for it to go high first.
            armed_q      <= (shift_q != '0) || p_q || stop_q;
            state_q      <= StIdle;
          end else if (strobe) begin
            stop_q <= rx_s;
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_parity_word_receiver.sv
// Randomized scoreboard bench for parity_word_receiver (BIT_CYCLES=4, DATA_W=8).
module tb_parity_word_receiver;
  import parity_rx_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned BC = 4;
  // Word pulse lands: 2 sync cycles + (DW+2) bits + half bit + output register.
  localparam int unsigned WordLat = 2 + (DW + 2) * BC + BC / 2 + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          serial_in = 1'b1;
  logic          parity_control = 1'b0;
  logic [DW-1:0] data_out;
  logic          word_valid;
  logic          parity_error;
  logic          busy;
`ifdef FRAMING_CHECK_EN
  logic          frame_error;
`endif

  parity_word_receiver #(
    .DATA_W(DW),
    .BIT_CYCLES(BC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .parity_control(parity_control),
    .data_out      (data_out),
    .word_valid    (word_valid),
    .parity_error  (parity_error),
`ifdef FRAMING_CHECK_EN
    .frame_error   (frame_error),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] last_data = '0;

  // Scoreboard: every word_valid cycle must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (!reset && word_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_word", word_valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("word_cycle", cyc, e.cyc);
        check_eq("data_out", data_out, e.data);
        check_eq("parity_error", parity_error, e.perr);
`ifdef FRAMING_CHECK_EN
        check_eq("frame_error", frame_error, e.ferr);
`endif
        last_data = e.data;
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends start, data LSB first, parity, stop; nbits < 11 truncates the frame.
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stop,
                            input logic mode, input bit toggle, input int nbits);
    logic [10:0] bits;
    exp_t e;
    bits = {stop, p, d, 1'b0};
    parity_control = mode;
    e.cyc  = cyc + WordLat;
    e.data = d;
    e.perr = (($countones(d) + int'(p)) % 2 == 1) != (mode == PARITY_ODD);
    e.ferr = !stop;
    if (nbits == 11) exp_q.push_back(e);
    for (int k = 0; k < nbits; k++) begin
      serial_in = bits[k];
      if (toggle && k == 4) parity_control = !mode;
      if (k == 5) check_eq("busy_mid_frame", busy, 1'b1);
      tick(BC);
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          p, stop, mode;
    tick(3);
    check_eq("rst_data_out", data_out, '0);
    check_eq("rst_word_valid", word_valid, 1'b0);
    check_eq("rst_parity_error", parity_error, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
`ifdef FRAMING_CHECK_EN
    check_eq("rst_frame_error", frame_error, 1'b0);
`endif
    reset = 1'b0;
    tick(5);

    // Directed: even good, even bad, odd with mid-word control toggle.
    send_frame(8'hB4, 1'b0, 1'b1, PARITY_EVEN, 1'b0, 11);
    tick(3);
    send_frame(8'hB4, 1'b1, 1'b1, PARITY_EVEN, 1'b0, 11);
    tick(3);
    send_frame(8'h34, 1'b0, 1'b1, PARITY_ODD, 1'b1, 11);
    tick(20);

    // Start glitch: one low cycle on the line.
    serial_in = 1'b0;
    tick(1);
    serial_in = 1'b1;
    tick(2);
    check_eq("glitch_busy_high", busy, 1'b1);
    tick(2);
    check_eq("glitch_busy_low", busy, 1'b0);
    tick(50);
    check_eq("glitch_data_held", data_out, last_data);

    // Reset in the middle of D4, then a clean frame.
    send_frame(8'hC3, 1'b0, 1'b1, PARITY_EVEN, 1'b0, 5);
    serial_in = 1'b0;
    tick(2);
    reset = 1'b1;
    #1;
    check_eq("midrst_data_out", data_out, '0);
    check_eq("midrst_parity_error", parity_error, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_word_valid", word_valid, 1'b0);
    last_data = '0;
    tick(2);
    reset = 1'b0;
    serial_in = 1'b1;
    tick(5);
    send_frame(8'h5A, 1'b0, 1'b1, PARITY_EVEN, 1'b0, 11);
    tick(4);

`ifdef FRAMING_CHECK_EN
    // Bad stop bit followed immediately by a good frame.
    send_frame(8'h0F, 1'b0, 1'b0, PARITY_EVEN, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 1'b1, PARITY_EVEN, 1'b0, 11);
    tick(4);
`endif

    // Random frames with random gaps, including back-to-back.
    for (int i = 0; i < 24; i++) begin
      d    = DW'($urandom);
      p    = 1'($urandom);
      mode = 1'($urandom);
      stop = 1'($urandom_range(0, 3) != 0);
      if (d == '0 && !p) stop = 1'b1;
      send_frame(d, p, stop, mode, 1'($urandom), 11);
      serial_in = 1'b1;
      tick($urandom_range(0, 3));
    end
    serial_in = 1'b1;
    tick(60);

    // Line held low: exactly one zero word, then nothing until the line recovers.
    begin
      exp_t e;
      parity_control = PARITY_EVEN;
      e.cyc = cyc + WordLat;
      e.data = '0;
      e.perr = 1'b0;
      e.ferr = 1'b1;
      exp_q.push_back(e);
      serial_in = 1'b0;
      tick(60);
      check_eq("low_line_busy", busy, 1'b0);
      tick(60);
      check_eq("low_line_still_idle", busy, 1'b0);
      serial_in = 1'b1;
      tick(6);
    end
    send_frame(8'h81, 1'b1, 1'b1, PARITY_ODD, 1'b0, 11);
    tick(60);

    check_eq("pending_words", exp_q.size(), 0);
    check_eq("final_busy", busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
